fifo_fnv_reader: RTL and testbench

Read-side consumer for the async FIFO. It drains bytes from the FIFO's first-word-fall-through read port in the read clock domain and folds each byte into a running 32-bit FNV-1a hash. The multiply by the FNV prime is done as a fixed 3-cycle shift-add sequence, which keeps area small. The result feeds the I2C register-read path.

---
 rtl/fnv_pkg.sv | 26 ++
 rtl/fnv_mul_seq.sv | 58 +++++
 rtl/fifo_fnv_reader.sv | 120 ++++++++++++
 tb/tb_fifo_fnv_reader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fnv_pkg.sv
// Shared constants and types for the FNV-1a FIFO reader.
// Contents: FNV-1a 32-bit offset basis and prime, reader FSM state encoding,
// and a helper that yields one shift-add partial product of the prime.
package fnv_pkg;

    localparam int unsigned HASH_W = 32;

    localparam logic [HASH_W-1:0] FNV_OFFSET_32 = 32'h811C9DC5;
    localparam logic [HASH_W-1:0] FNV_PRIME_32  = 32'h01000193;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_POP  = 3'd1,
        ST_M0   = 3'd2,
        ST_M1   = 3'd3,
        ST_M2   = 3'd4
    } state_t;

    // x shifted by sh when bit sh of the prime is set, else zero; the
    // multiplier sums these for the set bits {0,1,4,7,8,24}.
    function automatic logic [HASH_W-1:0] prime_term(input logic [HASH_W-1:0] x,
                                                     input logic [4:0]        sh);
        return FNV_PRIME_32[sh] ? (x << sh) : '0;
    endfunction

endpackage

// File: rtl/fnv_mul_seq.sv
// Three-cycle shift-add multiplier by the FNV-1a 32-bit prime.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   start        load x_in and clear the accumulator (one-cycle pulse)
//   x_in         multiplicand (hash XOR byte)
//   result_c     acc + final partial products; valid while done_c is high
//   done_c       high in the third cycle after start
module fnv_mul_seq
    import fnv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [HASH_W-1:0] x_in,
    output logic [HASH_W-1:0] result_c,
    output logic              done_c
);

    logic [HASH_W-1:0] x;
    logic [HASH_W-1:0] acc;
    logic [1:0]        phase;
    logic              running;

    // Accumulate two partial products per cycle; the last two are added
    // combinationally so the product is available in the third cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x       <= '0;
            acc     <= '0;
            phase   <= 2'd0;
            running <= 1'b0;
        end else if (start) begin
            x       <= x_in;
            acc     <= '0;
            phase   <= 2'd0;
            running <= 1'b1;
        end else if (running) begin
            case (phase)
                2'd0: begin
                    acc   <= acc + prime_term(x, 5'd0) + prime_term(x, 5'd1);
                    phase <= 2'd1;
                end
                2'd1: begin
                    acc   <= acc + prime_term(x, 5'd4) + prime_term(x, 5'd7);
                    phase <= 2'd2;
                end
                default: begin
                    phase   <= 2'd0;
                    running <= 1'b0;
                end
            endcase
        end
    end

    assign result_c = acc + prime_term(x, 5'd8) + prime_term(x, 5'd24);
    assign done_c   = running && (phase == 2'd2);

endmodule

// File: rtl/fifo_fnv_reader.sv
// Drains bytes from a FWFT FIFO read port and folds each into a running
// 32-bit FNV-1a hash (5 cycles per byte: IDLE, POP, M0, M1, M2).
// Ports:
//   rclk, rrst_n   read-domain clock, async active-low reset
//   rempty, rdata  FIFO empty flag and head data (valid while !rempty)
//   rinc           FIFO pop strobe, high in the POP state only
//   en             permits starting a new byte
//   hash_clear     restart hash and count at the offset basis
//   hash           current hash value
//   byte_count     bytes folded since reset/clear (wraps)
//   hash_valid     one-cycle pulse after each hash update
//   busy           high whenever the FSM is not in IDLE
module fifo_fnv_reader
    import fnv_pkg::*;
#(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic              rclk,
    input  logic              rrst_n,
    input  logic              rempty,
    input  logic [DSIZE-1:0]  rdata,
    output logic              rinc,
    input  logic              en,
    input  logic              hash_clear,
    output logic [HASH_W-1:0] hash,
    output logic [CNT_W-1:0]  byte_count,
    output logic              hash_valid,
    output logic              busy
);

    state_t            state;
    state_t            next_state;
    logic              clear_pend;
    logic              mul_start;
    logic              mul_done;
    logic [HASH_W-1:0] mul_result;

    // State register.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a clear in IDLE takes priority over starting a byte.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (!hash_clear && en && !rempty) next_state = ST_POP;
            ST_POP:  next_state = ST_M0;
            ST_M0:   next_state = ST_M1;
            ST_M1:   next_state = ST_M2;
            ST_M2:   next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        rinc      = 1'b0;
        busy      = 1'b1;
        mul_start = 1'b0;
        case (state)
            ST_IDLE: busy = 1'b0;
            ST_POP: begin
                rinc      = 1'b1;
                mul_start = 1'b1;
            end
            default: ;
        endcase
    end

    fnv_mul_seq u_mul (
        .clk      (rclk),
        .rst_n    (rrst_n),
        .start    (mul_start),
        .x_in     (hash ^ HASH_W'(rdata)),
        .result_c (mul_result),
        .done_c   (mul_done)
    );

    // Hash, counter and deferred-clear bookkeeping. A clear seen while a
    // byte is in flight (including in M2 itself) discards that byte.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            hash       <= FNV_OFFSET_32;
            byte_count <= '0;
            hash_valid <= 1'b0;
            clear_pend <= 1'b0;
        end else begin
            hash_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (hash_clear) begin
                        hash       <= FNV_OFFSET_32;
                        byte_count <= '0;
                    end
                end
                ST_M2: begin
                    clear_pend <= 1'b0;
                    if (clear_pend || hash_clear) begin
                        hash       <= FNV_OFFSET_32;
                        byte_count <= '0;
                    end else if (mul_done) begin
                        hash       <= mul_result;
                        byte_count <= byte_count + CNT_W'(1);
                        hash_valid <= 1'b1;
                    end
                end
                default: begin
                    if (hash_clear) clear_pend <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_fnv_reader.sv
module tb_fifo_fnv_reader;

    localparam int unsigned CNT_W  = 16;
    localparam logic [31:0] OFFSET = 32'h811C9DC5;

    logic             rclk = 1'b0;
    logic             rrst_n = 1'b0;
    logic             rempty;
    logic [7:0]       rdata;
    logic             rinc;
    logic             en = 1'b0;
    logic             hash_clear = 1'b0;
    logic [31:0]      hash;
    logic [CNT_W-1:0] byte_count;
    logic             hash_valid;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    fifo_fnv_reader #(.DSIZE(8), .CNT_W(CNT_W)) dut (
        .rclk       (rclk),
        .rrst_n     (rrst_n),
        .rempty     (rempty),
        .rdata      (rdata),
        .rinc       (rinc),
        .en         (en),
        .hash_clear (hash_clear),
        .hash       (hash),
        .byte_count (byte_count),
        .hash_valid (hash_valid),
        .busy       (busy)
    );

    always #5 rclk = ~rclk;

    // FWFT FIFO model
    logic [7:0] mem [0:255];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         cyc = 0;
    int         last_pop = 0;
    int         pop_cyc [0:255];
    int         valid_cnt = 0;

    assign rempty = (rd_ptr == wr_ptr);
    assign rdata  = mem[rd_ptr[7:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(posedge rclk) begin
        cyc <= cyc + 1;
        if (rinc) begin
            check("rinc_while_empty", 32'(rempty), 32'd0);
            pop_cyc[rd_ptr[7:0]] <= cyc;
            last_pop <= cyc;
            rd_ptr <= rd_ptr + 1;
        end
    end

    // Scoreboard
    typedef struct packed {
        logic [31:0]      h;
        logic [CNT_W-1:0] c;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] model_h = OFFSET;
    logic [CNT_W-1:0] model_c = '0;

    function automatic logic [31:0] fnv_ref(input logic [31:0] h, input logic [7:0] b);
        logic [31:0] t;
        t = h ^ {24'd0, b};
        return t * 32'h01000193;
    endfunction

    always @(negedge rclk) begin
        if (rrst_n && hash_valid) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'(hash_valid), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_hash", hash, mon_e.h);
                check("sb_count", 32'(byte_count), 32'(mon_e.c));
                check("valid_latency", 32'(cyc - last_pop), 32'd4);
            end
        end
    end

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit discard);
        mem[wr_ptr[7:0]] = b;
        wr_ptr++;
        if (discard) begin
            model_h = OFFSET;
            model_c = '0;
        end else begin
            model_h = fnv_ref(model_h, b);
            model_c = model_c + CNT_W'(1);
            exp_q.push_back({model_h, model_c});
        end
    endtask

    task automatic do_clear();
        hash_clear = 1'b1;
        tick();
        hash_clear = 1'b0;
        model_h = OFFSET;
        model_c = '0;
        tick();
        check("clear_hash", hash, OFFSET);
        check("clear_count", 32'(byte_count), 32'd0);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (!(rd_ptr == wr_ptr && !busy && exp_q.size() == 0) && n < budget) begin
            tick();
            n++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_pops(input int target);
        int n = 0;
        while (rd_ptr < target && n < 200) begin
            tick();
            n++;
        end
        check("pop_reached", 32'(rd_ptr), 32'(target));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int vbase;
        logic [7:0] foobar [0:5];
        foobar[0] = 8'h66; foobar[1] = 8'h6F; foobar[2] = 8'h6F;
        foobar[3] = 8'h62; foobar[4] = 8'h61; foobar[5] = 8'h72;

        // Reset with FIFO empty
        en = 1'b1;
        repeat (3) tick();
        check("rst_hash", hash, OFFSET);
        check("rst_count", 32'(byte_count), 32'd0);
        check("rst_rinc", 32'(rinc), 32'd0);
        check("rst_valid", 32'(hash_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rrst_n = 1'b1;
        repeat (50) tick();
        check("empty_no_pop", 32'(rd_ptr), 32'd0);
        check("empty_hash", hash, OFFSET);
        check("empty_count", 32'(byte_count), 32'd0);
        check("empty_busy", 32'(busy), 32'd0);

        // Single byte "a"
        push_byte(8'h61, 1'b0);
        drain(100);
        check("a_pops", 32'(rd_ptr), 32'd1);
        check("a_hash", hash, 32'hE40C292C);
        check("a_count", 32'(byte_count), 32'd1);

        // "foobar" back-to-back
        do_clear();
        base  = rd_ptr;
        vbase = valid_cnt;
        for (int i = 0; i < 6; i++) push_byte(foobar[i], 1'b0);
        drain(200);
        check("foobar_hash", hash, 32'hBF9CF968);
        check("foobar_count", 32'(byte_count), 32'd6);
        check("foobar_valids", 32'(valid_cnt - vbase), 32'd6);
        for (int j = 1; j < 6; j++)
            check("pop_spacing", 32'(pop_cyc[base + j] - pop_cyc[base + j - 1]), 32'd5);

        // Clear during M1 of the third byte
        do_clear();
        base = rd_ptr;
        for (int i = 0; i < 6; i++) push_byte(foobar[i], (i == 2));
        wait_pops(base + 3);
        tick();
        hash_clear = 1'b1;
        tick();
        hash_clear = 1'b0;
        wait_pops(base + 4);
        check("midclear_hash", hash, OFFSET);
        check("midclear_count", 32'(byte_count), 32'd0);
        drain(200);
        check("bar_hash", hash, model_h);
        check("bar_count", 32'(byte_count), 32'd3);

        // en held low with bytes queued
        do_clear();
        en = 1'b0;
        base = rd_ptr;
        push_byte(8'h01, 1'b0);
        push_byte(8'h02, 1'b0);
        push_byte(8'hA5, 1'b0);
        push_byte(8'hFF, 1'b0);
        repeat (20) tick();
        check("en0_no_pop", 32'(rd_ptr), 32'(base));
        check("en0_busy", 32'(busy), 32'd0);
        en = 1'b1;
        drain(200);
        check("en1_pops", 32'(rd_ptr), 32'(base + 4));
        check("en1_count", 32'(byte_count), 32'd4);
        check("en1_hash", hash, model_h);

        // Reset during M0
        base = rd_ptr;
        push_byte(8'h55, 1'b1);
        push_byte(8'h7A, 1'b0);
        wait_pops(base + 1);
        check("m0_busy", 32'(busy), 32'd1);
        rrst_n = 1'b0;
        #1;
        check("arst_hash", hash, OFFSET);
        check("arst_count", 32'(byte_count), 32'd0);
        check("arst_rinc", 32'(rinc), 32'd0);
        check("arst_valid", 32'(hash_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        tick();
        tick();
        check("arst_hold_pop", 32'(rd_ptr), 32'(base + 1));
        rrst_n = 1'b1;
        drain(200);
        check("resume_pops", 32'(rd_ptr), 32'(base + 2));
        check("resume_hash", hash, model_h);
        check("resume_count", 32'(byte_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
